// File: rtl/npc_pkg.sv
// Shared encodings and helpers for the next-PC predictor and its branch target buffer.
package npc_pkg;

  // ex_kind encodings for the instruction resolving in EX
  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_BR   = 2'd1;
  localparam logic [1:0] KIND_J    = 2'd2;
  localparam logic [1:0] KIND_JR   = 2'd3;

  // 2-bit saturating counter states; bit 1 set means "predict taken"
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // Saturating step of a branch counter toward the resolved direction.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == CTR_ST) ? CTR_ST : (ctr + 2'd1);
    end else begin
      res = (ctr == CTR_SNT) ? CTR_SNT : (ctr - 2'd1);
    end
    return res;
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer: async-cleared valid bits, one combinational
// read port for fetch and one write port that applies the resolved EX outcome.
module btb_table
  import npc_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 64,
  parameter int IDX_W     = $clog2(BTB_DEPTH),
  parameter int TAG_W     = XLEN - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  output logic             rd_hit_o,
  output logic [XLEN-1:0]  rd_target_o,
  output logic             rd_is_jump_o,
  output logic [1:0]       rd_ctr_o,
  input  logic             wr_act_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [1:0]       wr_kind_i,
  input  logic             wr_taken_i,
  input  logic [XLEN-1:0]  wr_target_i
);

  logic [BTB_DEPTH-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q    [BTB_DEPTH];
  logic [XLEN-1:0]      target_q [BTB_DEPTH];
  logic                 jump_q   [BTB_DEPTH];
  logic [1:0]           ctr_q    [BTB_DEPTH];

  logic                 w_hit_s;
  logic                 we_s;
  logic [XLEN-1:0]      new_target_s;
  logic                 new_jump_s;
  logic [1:0]           new_ctr_s;

  // Fetch-side read: old contents are seen even when EX writes the same index.
  always_comb begin
    rd_hit_o     = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    rd_target_o  = target_q[rd_idx_i];
    rd_is_jump_o = jump_q[rd_idx_i];
    rd_ctr_o     = ctr_q[rd_idx_i];
  end

  assign w_hit_s = valid_q[wr_idx_i] && (tag_q[wr_idx_i] == wr_tag_i);

  // Decide whether and what to write for the resolving instruction.
  always_comb begin
    we_s         = 1'b0;
    new_target_s = wr_target_i;
    new_jump_s   = 1'b1;
    new_ctr_s    = CTR_ST;
    case (wr_kind_i)
      KIND_J, KIND_JR: begin
        we_s = wr_act_i;
      end
      KIND_BR: begin
        new_jump_s = 1'b0;
        if (w_hit_s) begin
          we_s         = wr_act_i;
          new_ctr_s    = ctr_next(ctr_q[wr_idx_i], wr_taken_i);
          new_target_s = wr_taken_i ? wr_target_i : target_q[wr_idx_i];
        end else begin
          we_s      = wr_act_i & wr_taken_i;
          new_ctr_s = CTR_WT;
        end
      end
      default: begin
        we_s = 1'b0;
      end
    endcase
  end

  // Valid bits are the only reset state; everything else is qualified by them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
    end else if (we_s) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Entry payload storage, written alongside the valid bit.
  always_ff @(posedge clk) begin
    if (we_s) begin
      tag_q[wr_idx_i]    <= wr_tag_i;
      target_q[wr_idx_i] <= new_target_s;
      jump_q[wr_idx_i]   <= new_jump_s;
      ctr_q[wr_idx_i]    <= new_ctr_s;
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC register with BTB-based next-PC prediction, EX resolution compare,
// fetch redirect on mispredict and a wrapping mispredict counter.
module pc_predict_unit
  import npc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              BTB_DEPTH = 64,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEFAULT_RESET_PC),
  localparam int             IDX_W     = $clog2(BTB_DEPTH)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] pred_npc_o,
  output logic            pred_taken_o,
  input  logic            ex_valid,
  input  logic [1:0]      ex_kind,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic [XLEN-1:0] ex_pred_npc,
  output logic            flush_o,
  output logic [XLEN-1:0] mispred_cnt_o
);

  localparam int              TAG_W = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] FOUR  = XLEN'(3'd4);
  localparam logic [XLEN-1:0] ONE   = XLEN'(1'b1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cnt_q, cnt_d;

  logic            hit_s;
  logic [XLEN-1:0] btb_target_s;
  logic            btb_jump_s;
  logic [1:0]      btb_ctr_s;
  logic            act_s;
  logic            redirect_s;
  logic [XLEN-1:0] actual_npc_s;

  btb_table #(
    .XLEN      (XLEN),
    .BTB_DEPTH (BTB_DEPTH),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_btb (
    .clk          (clk),
    .rstn         (rstn),
    .rd_idx_i     (pc_q[IDX_W+1:2]),
    .rd_tag_i     (pc_q[XLEN-1:IDX_W+2]),
    .rd_hit_o     (hit_s),
    .rd_target_o  (btb_target_s),
    .rd_is_jump_o (btb_jump_s),
    .rd_ctr_o     (btb_ctr_s),
    .wr_act_i     (act_s),
    .wr_idx_i     (ex_pc[IDX_W+1:2]),
    .wr_tag_i     (ex_pc[XLEN-1:IDX_W+2]),
    .wr_kind_i    (ex_kind),
    .wr_taken_i   (ex_taken),
    .wr_target_i  (ex_target)
  );

  // Fetch-side prediction from the current PC.
  always_comb begin
    pc_o         = pc_q;
    pc_plus4_o   = pc_q + FOUR;
    pred_taken_o = hit_s & (btb_jump_s | btb_ctr_s[1]);
    pred_npc_o   = pred_taken_o ? btb_target_s : (pc_q + FOUR);
  end

  // EX-side resolution: jumps always go to the target, branches only when taken.
  always_comb begin
    act_s         = ex_valid & (ex_kind != KIND_NONE);
    redirect_s    = (ex_kind == KIND_J) | (ex_kind == KIND_JR) | ex_taken;
    actual_npc_s  = redirect_s ? ex_target : (ex_pc + FOUR);
    flush_o       = act_s & (actual_npc_s != ex_pred_npc);
    mispred_cnt_o = cnt_q;
  end

  // Next PC priority: redirect, then stall hold, then prediction.
  always_comb begin
    pc_d  = pred_npc_o;
    cnt_d = cnt_q;
    if (flush_o) begin
      pc_d  = actual_npc_s;
      cnt_d = cnt_q + ONE;
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pred_npc_o;
    end
  end

  // PC and mispredict counter state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Randomised bench for pc_predict_unit against a behavioural model of the
// predictor, BTB and mispredict counter.
module tb_pc_predict_unit;

  localparam int          DEPTH = 64;
  localparam int          IDXW  = 6;
  localparam logic [31:0] RPC   = 32'h0000_3000;

  logic        clk;
  logic        rstn;
  logic        stall;
  logic [31:0] pc_o, pc_plus4_o, pred_npc_o, mispred_cnt_o;
  logic        pred_taken_o, flush_o;
  logic        ex_valid, ex_taken;
  logic [1:0]  ex_kind;
  logic [31:0] ex_pc, ex_target, ex_pred_npc;

  pc_predict_unit #(
    .XLEN      (32),
    .BTB_DEPTH (DEPTH),
    .RESET_PC  (RPC)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .stall         (stall),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .pred_npc_o    (pred_npc_o),
    .pred_taken_o  (pred_taken_o),
    .ex_valid      (ex_valid),
    .ex_kind       (ex_kind),
    .ex_pc         (ex_pc),
    .ex_taken      (ex_taken),
    .ex_target     (ex_target),
    .ex_pred_npc   (ex_pred_npc),
    .flush_o       (flush_o),
    .mispred_cnt_o (mispred_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc, m_cnt;
  bit          m_valid  [DEPTH];
  logic [31:0] m_tag    [DEPTH];
  logic [31:0] m_target [DEPTH];
  bit          m_jump   [DEPTH];
  int          m_ctr    [DEPTH];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> (IDXW + 2);
  endfunction

  task automatic model_reset();
    m_pc  = RPC;
    m_cnt = 32'd0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  // Called at a negedge: drive EX inputs, check outputs, advance model, wait next negedge.
  task automatic step(input logic v, input logic [1:0] k, input logic [31:0] epc,
                      input logic tk, input logic [31:0] tgt, input logic [31:0] epred,
                      input logic st);
    int          fi, wi;
    bit          hit, pt, act, fl, whit;
    logic [31:0] pn, actual;
    ex_valid = v; ex_kind = k; ex_pc = epc; ex_taken = tk;
    ex_target = tgt; ex_pred_npc = epred; stall = st;
    #1;
    fi  = idx_of(m_pc);
    hit = m_valid[fi] && (m_tag[fi] == tag_of(m_pc));
    pt  = hit && (m_jump[fi] || m_ctr[fi] >= 2);
    pn  = pt ? m_target[fi] : m_pc + 32'd4;
    act    = v && (k != 2'd0);
    actual = (k >= 2'd2 || tk) ? tgt : epc + 32'd4;
    fl     = act && (actual != epred);
    check_eq("pc",         pc_o,          m_pc);
    check_eq("pc_plus4",   pc_plus4_o,    m_pc + 32'd4);
    check_eq("pred_taken", {31'd0, pred_taken_o}, {31'd0, pt});
    check_eq("pred_npc",   pred_npc_o,    pn);
    check_eq("flush",      {31'd0, flush_o}, {31'd0, fl});
    check_eq("mispred",    mispred_cnt_o, m_cnt);
    // advance model to the state after the coming edge
    if (fl) begin
      m_pc  = actual;
      m_cnt = m_cnt + 32'd1;
    end else if (!st) begin
      m_pc = pn;
    end
    if (act) begin
      wi   = idx_of(epc);
      whit = m_valid[wi] && (m_tag[wi] == tag_of(epc));
      if (k >= 2'd2) begin
        m_valid[wi] = 1'b1; m_tag[wi] = tag_of(epc); m_target[wi] = tgt;
        m_jump[wi] = 1'b1; m_ctr[wi] = 3;
      end else if (whit) begin
        m_ctr[wi]  = tk ? ((m_ctr[wi] == 3) ? 3 : m_ctr[wi] + 1)
                        : ((m_ctr[wi] == 0) ? 0 : m_ctr[wi] - 1);
        if (tk) m_target[wi] = tgt;
        m_jump[wi] = 1'b0;
      end else if (tk) begin
        m_valid[wi] = 1'b1; m_tag[wi] = tag_of(epc); m_target[wi] = tgt;
        m_jump[wi] = 1'b0; m_ctr[wi] = 2;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pc"},         pc_o,          RPC);
    check_eq({tag, "_pc_plus4"},   pc_plus4_o,    RPC + 32'd4);
    check_eq({tag, "_pred_taken"}, {31'd0, pred_taken_o}, 32'd0);
    check_eq({tag, "_pred_npc"},   pred_npc_o,    RPC + 32'd4);
    check_eq({tag, "_flush"},      {31'd0, flush_o}, 32'd0);
    check_eq({tag, "_mispred"},    mispred_cnt_o, 32'd0);
  endtask

  // Called at a negedge: assert reset between edges, check immediately, release at next negedge.
  task automatic mid_reset();
    ex_valid = 1'b0; stall = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
    return 32'h0000_3000 + 32'($urandom_range(0, 127)) * 32'd4;
  endfunction

  initial begin
    logic [31:0] a, t, p;
    logic [1:0]  k;
    logic        tk;
    rstn = 1'b0; stall = 1'b0; ex_valid = 1'b0; ex_kind = 2'd0; ex_pc = 32'd0;
    ex_taken = 1'b0; ex_target = 32'd0; ex_pred_npc = 32'd0;
    model_reset();
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rstn = 1'b1;

    // quiet sequential fetch
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    // taken branch miss allocates and redirects, then jump back to re-fetch it
    step(1'b1, 2'd1, 32'h3010, 1'b1, 32'h3040, 32'h3014, 1'b0);
    step(1'b1, 2'd2, 32'h3040, 1'b0, 32'h3010, 32'h3044, 1'b0);
    step(1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    // counter walk down with a stall held
    for (int i = 0; i < 6; i++) step(1'b1, 2'd1, 32'h3010, 1'b0, 32'h3040, 32'h3014, 1'b1);
    // mispredict while stalled redirects anyway
    step(1'b1, 2'd3, 32'h3020, 1'b0, 32'h3200, 32'h3024, 1'b1);
    // aliasing entry overwrite
    step(1'b1, 2'd2, 32'h3110, 1'b0, 32'h3500, 32'h3500, 1'b0);
    step(1'b1, 2'd2, 32'h3500, 1'b0, 32'h3010, 32'h3504, 1'b0);

    for (int n = 0; n < 1500; n++) begin
      if (n % 250 == 249) begin
        mid_reset();
      end else begin
        a  = rand_addr();
        t  = rand_addr();
        k  = 2'($urandom_range(0, 3));
        tk = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0: p = a + 32'd4;
          1: p = t;
          2: p = (k >= 2'd2 || tk) ? t : a + 32'd4;
          default: p = rand_addr();
        endcase
        step($urandom_range(0, 4) != 0, k, a, tk, t, p, $urandom_range(0, 4) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
Parametrised successor to the combinational next-PC logic. Owns the fetch PC register and predicts the next PC with a direct-mapped branch target buffer carrying 2-bit saturating counters. The prediction is made at IF. Resolved branches and jumps from EX update the table. A mispredict redirects fetch and raises a one-cycle squash to the IF/ID stages.

Parameters:
XLEN, 32, address/data width
BTB_DEPTH, 64, number of BTB entries; power of two, minimum 4
RESET_PC, 32'h0000_3000, PC value loaded at reset
IDX_W, $clog2(BTB_DEPTH), index width (derived; not overridden)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
stall  in  1  hold PC (hazard or load-use)
pc_o  out  XLEN  current fetch PC
pc_plus4_o  out  XLEN  pc_o+4, for link-register writes
pred_npc_o  out  XLEN  predicted next PC; travels down the pipe with the instruction
pred_taken_o  out  1  BTB hit and predicted taken
ex_valid  in  1  EX holds a valid instruction this cycle
ex_kind  in  2  0 none, 1 conditional branch, 2 direct jump (J/JAL), 3 indirect jump (JR/JALR)
ex_pc  in  XLEN  PC of the EX instruction
ex_taken  in  1  resolved branch outcome; ignored for kinds 2 and 3
ex_target  in  XLEN  resolved target
ex_pred_npc  in  XLEN  pred_npc_o carried with the EX instruction
flush_o  out  1  mispredict; squash IF/ID this cycle
mispred_cnt_o  out  XLEN  count of mispredicts, wraps

Behaviour:
Index and tag
- idx = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
- Each entry holds: valid, tag, target (XLEN), is_jump, ctr[1:0].

Prediction (combinational on pc_o)
- hit = valid[idx] and tag matches.
- pred_taken_o = hit & (is_jump | ctr[1]).
- pred_npc_o = pred_taken_o ? target : pc_o+4.

Resolution (combinational on EX inputs)
- act = ex_valid & ex_kind!=0.
- actual_npc = (ex_kind>=2 | ex_taken) ? ex_target : ex_pc+4.
- flush_o = act & (actual_npc != ex_pred_npc).

PC register
- Reset: pc_o = RESET_PC.
- Each edge, in priority order: flush_o loads actual_npc; else stall holds; else loads pred_npc_o.
- Redirect beats stall.

BTB update (on the edge, when act)
- Kinds 2 and 3: write valid=1, tag, target=ex_target, is_jump=1, ctr=2'b11. Overwrite on hit or miss.
- Kind 1, tag hit: ctr saturating +1 if taken, -1 if not taken, clamped to 00..11. target=ex_target when taken; is_jump=0.
- Kind 1, miss, taken: allocate valid=1, tag, target, is_jump=0, ctr=2'b10.
- Kind 1, miss, not taken: no write.

Table timing and reset
- Read and write to the same index in the same cycle: prediction uses the old contents; the new contents are visible next cycle.
- Reset clears all valid bits asynchronously. Tag, target and ctr are not reset.
- Reset mid-operation returns pc_o to RESET_PC immediately, flush_o=0, mispred_cnt_o=0.

Mispredict counter
- mispred_cnt_o increments by 1 on each edge with flush_o=1 and wraps at 2^XLEN.

Other rules
- pc_plus4_o and all adders wrap modulo 2^XLEN.
- No output depends on stall except the PC hold.
- Reset values: pc_o=RESET_PC, pc_plus4_o=RESET_PC+4, pred_taken_o=0, pred_npc_o=RESET_PC+4, flush_o=0, mispred_cnt_o=0.

Decomposition:
- Package npc_pkg holds:
  - ex_kind encodings: KIND_NONE, KIND_BR, KIND_J, KIND_JR.
  - Counter constants: CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11.
  - Default RESET_PC.
- One sub-module, btb_table: storage, async-cleared valid bits, read port on idx, write port with counter update. pc_predict_unit holds the PC register, resolution compare and mispredict counter.

Test Plan:
1. Hold rstn=0, then release, stall=0, no EX activity -> pc_o 0x3000, 0x3004, 0x3008; pred_taken_o=0, flush_o=0.
2. Kind 1 at 0x3010, taken, target 0x3040, ex_pred_npc=0x3014 -> flush_o=1 that cycle; next pc_o=0x3040; mispred_cnt_o=1. Re-fetch 0x3010 -> pred_taken_o=1, pred_npc_o=0x3040.
3. Counter walk at 0x3010, starting ctr=10:
   - taken, taken -> 11;
   - not taken -> 10, still predicts 0x3040;
   - not taken -> 01, pred_npc_o=0x3014; saturates at 00 after further not-taken.
4. stall=1 for 3 cycles -> pc_o held. stall=1 together with a mispredict to 0x3200 -> pc_o=0x3200 next cycle.
5. Aliasing, DEPTH=64 (0x3010 and 0x3110 share idx 4): entry from 0x3010 present, fetch 0x3110 -> pred_taken_o=0. Kind 2 at 0x3110, target 0x3500 -> entry overwritten; 0x3010 now misses.
6. Kind 3 at 0x3020 predicted 0x3400, resolves 0x3500 -> flush_o=1, pc_o=0x3500, stored target becomes 0x3500. Assert rstn low mid-run -> pc_o=0x3000 asynchronously, all entries miss after release.
